// File: rtl/cook_time_countdown.sv
// cook_time_countdown
//
// Counts down a microwave cook time held as BCD MM:SS. One second is removed
// for every TICKS_PER_SEC pulses of the 100 ms tick_in stream. The block
// reports run/pause/done status to the control FSM and drives BCD digits to
// the display path.
//
// Optional feature: define COOK_DONE_BEEP_EN to build the completion beep.
// Without it, beep is tied low and no beep counter exists.
//
// Parameters:
//   TICKS_PER_SEC - tick_in pulses per decremented second
//   BEEP_TICKS    - tick_in pulses that beep stays high after completion
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-low reset
//   tick_in    in   single-cycle 100 ms pulse
//   load       in   capture min_in/sec_in (IDLE and DONE only)
//   min_in     in   BCD minutes, each digit clamped to 9
//   sec_in     in   BCD seconds, tens clamped to 5, ones clamped to 9
//   start      in   start (from IDLE) or resume (from PAUSE)
//   pause      in   pause a running countdown
//   cancel     in   abort and clear to 00:00 in any state
//   min_out    out  current BCD minutes
//   sec_out    out  current BCD seconds
//   running    out  high in RUN
//   paused     out  high in PAUSE
//   done       out  high in DONE
//   done_pulse out  one-cycle pulse on entry to DONE
//   beep       out  completion beep (optional feature)

module cook_time_countdown #(
  parameter int TICKS_PER_SEC = 10,
  parameter int BEEP_TICKS    = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       load,
  input  logic [7:0] min_in,
  input  logic [7:0] sec_in,
  input  logic       start,
  input  logic       pause,
  input  logic       cancel,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       running,
  output logic       paused,
  output logic       done,
  output logic       done_pulse,
  output logic       beep
);

  localparam int SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [SUB_W-1:0] sub_reg, sub_next;
  logic [7:0]       min_reg, min_next;
  logic [7:0]       sec_reg, sec_next;
  logic             running_reg, paused_reg, done_reg, done_pulse_reg;
  logic             done_pulse_next;

  // ---------------------------------------------------------------------
  // Load clamping, digit by digit
  // ---------------------------------------------------------------------
  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  logic [7:0] min_clamped, sec_clamped;
  assign min_clamped = {clamp_digit(min_in[7:4], 4'd9), clamp_digit(min_in[3:0], 4'd9)};
  assign sec_clamped = {clamp_digit(sec_in[7:4], 4'd5), clamp_digit(sec_in[3:0], 4'd9)};

  // ---------------------------------------------------------------------
  // BCD decrement by one second, saturating at 00:00
  // ---------------------------------------------------------------------
  logic [7:0] min_dec, sec_dec;
  logic       time_zero, dec_zero;

  assign time_zero = (min_reg == 8'h00) && (sec_reg == 8'h00);

  always_comb begin
    min_dec = min_reg;
    sec_dec = sec_reg;
    if (!time_zero) begin
      if (sec_reg[3:0] != 4'd0) begin
        sec_dec[3:0] = sec_reg[3:0] - 4'd1;
      end else begin
        sec_dec[3:0] = 4'd9;
        if (sec_reg[7:4] != 4'd0) begin
          sec_dec[7:4] = sec_reg[7:4] - 4'd1;
        end else begin
          // Seconds wrap to 59 and a minute is borrowed.
          sec_dec[7:4] = 4'd5;
          if (min_reg[3:0] != 4'd0) begin
            min_dec[3:0] = min_reg[3:0] - 4'd1;
          end else begin
            min_dec[3:0] = 4'd9;
            min_dec[7:4] = min_reg[7:4] - 4'd1;
          end
        end
      end
    end
  end

  assign dec_zero = (min_dec == 8'h00) && (sec_dec == 8'h00);

  // ---------------------------------------------------------------------
  // Next-state logic. Priority: cancel > pause > start > load.
  // A pause masks start/load in every state, and start masks load.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    sub_next   = sub_reg;
    min_next   = min_reg;
    sec_next   = sec_reg;

    if (cancel) begin
      state_next = IDLE;
      sub_next   = '0;
      min_next   = 8'h00;
      sec_next   = 8'h00;
    end else if (pause) begin
      // Any coincident tick is dropped.
      if (state_reg == RUN) begin
        state_next = PAUSE;
      end
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            if (!time_zero) begin
              state_next = RUN;
              sub_next   = '0;
            end
          end else if (load) begin
            min_next = min_clamped;
            sec_next = sec_clamped;
          end
        end
        RUN: begin
          // start and load have no effect here; ticks keep counting.
          if (tick_in) begin
            if (sub_reg == SUB_W'(TICKS_PER_SEC - 1)) begin
              sub_next = '0;
              min_next = min_dec;
              sec_next = sec_dec;
              if (dec_zero) begin
                state_next = DONE;
              end
            end else begin
              sub_next = sub_reg + SUB_W'(1);
            end
          end
        end
        PAUSE: begin
          // Resume keeps the partial second; the resume-cycle tick is lost.
          if (start) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (!start && load) begin
            min_next   = min_clamped;
            sec_next   = sec_clamped;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign done_pulse_next = (state_next == DONE) && (state_reg != DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= IDLE;
      sub_reg        <= '0;
      min_reg        <= 8'h00;
      sec_reg        <= 8'h00;
      running_reg    <= 1'b0;
      paused_reg     <= 1'b0;
      done_reg       <= 1'b0;
      done_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sub_reg        <= sub_next;
      min_reg        <= min_next;
      sec_reg        <= sec_next;
      running_reg    <= (state_next == RUN);
      paused_reg     <= (state_next == PAUSE);
      done_reg       <= (state_next == DONE);
      done_pulse_reg <= done_pulse_next;
    end
  end

  assign min_out    = min_reg;
  assign sec_out    = sec_reg;
  assign running    = running_reg;
  assign paused     = paused_reg;
  assign done       = done_reg;
  assign done_pulse = done_pulse_reg;

  // ---------------------------------------------------------------------
  // Completion beep
  // ---------------------------------------------------------------------
`ifdef COOK_DONE_BEEP_EN
  localparam int BEEP_W = (BEEP_TICKS > 1) ? $clog2(BEEP_TICKS) : 1;

  logic              beep_reg;
  logic [BEEP_W-1:0] beep_cnt_reg;

  // beep only rises on DONE entry, so it cannot retrigger while in DONE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      beep_reg     <= 1'b0;
      beep_cnt_reg <= '0;
    end else if (cancel || load) begin
      beep_reg     <= 1'b0;
      beep_cnt_reg <= '0;
    end else if (done_pulse_next) begin
      beep_reg     <= 1'b1;
      beep_cnt_reg <= '0;
    end else if (beep_reg && tick_in) begin
      if (beep_cnt_reg == BEEP_W'(BEEP_TICKS - 1)) begin
        beep_reg     <= 1'b0;
        beep_cnt_reg <= '0;
      end else begin
        beep_cnt_reg <= beep_cnt_reg + BEEP_W'(1);
      end
    end
  end

  assign beep = beep_reg;
`else
  // Keeps BEEP_TICKS referenced when the beep is not built.
  localparam int unused_beep_ticks = BEEP_TICKS;

  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_time_countdown.sv
// Scoreboard bench for cook_time_countdown. A driver applies one input vector
// per clock (directed scenarios, then random traffic), steps a reference model
// that keeps the cook time as a plain count of seconds, and queues the
// expected registered outputs. A monitor pops and compares after each edge.

module tb_cook_time_countdown;

  localparam int TPS    = 10;
  localparam int BEEP_T = 20;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick_in = 1'b0;
  logic       load = 1'b0;
  logic [7:0] min_in = 8'h00;
  logic [7:0] sec_in = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       cancel = 1'b0;
  logic [7:0] min_out, sec_out;
  logic       running, paused, done, done_pulse, beep;

  cook_time_countdown #(
    .TICKS_PER_SEC(TPS),
    .BEEP_TICKS   (BEEP_T)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tick_in   (tick_in),
    .load      (load),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .start     (start),
    .pause     (pause),
    .cancel    (cancel),
    .min_out   (min_out),
    .sec_out   (sec_out),
    .running   (running),
    .paused    (paused),
    .done      (done),
    .done_pulse(done_pulse),
    .beep      (beep)
  );

  always #5 clock = ~clock;

  // Expected output word: {min, sec, running, paused, done, done_pulse, beep}
  logic [20:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_sub = 0;
  int m_beep_left = 0;

  function automatic int clamp(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  function automatic int loaded_secs(input logic [7:0] mi, input logic [7:0] si);
    int m, s;
    m = clamp(int'(mi[7:4]), 9) * 10 + clamp(int'(mi[3:0]), 9);
    s = clamp(int'(si[7:4]), 5) * 10 + clamp(int'(si[3:0]), 9);
    return m * 60 + s;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic model_step(input logic r, input logic tk, input logic ld,
                            input logic st, input logic pa, input logic ca,
                            input logic [7:0] mi, input logic [7:0] si);
    logic entered;
    logic bp;
    entered = 1'b0;
    if (!r) begin
      m_mode = M_IDLE; m_secs = 0; m_sub = 0; m_beep_left = 0;
    end else begin
      if (ca) begin
        m_mode = M_IDLE; m_secs = 0; m_sub = 0;
      end else if (pa) begin
        if (m_mode == M_RUN) m_mode = M_PAUSE;
      end else begin
        case (m_mode)
          M_IDLE: begin
            if (st) begin
              if (m_secs != 0) begin m_mode = M_RUN; m_sub = 0; end
            end else if (ld) begin
              m_secs = loaded_secs(mi, si);
            end
          end
          M_RUN: begin
            if (tk) begin
              m_sub++;
              if (m_sub == TPS) begin
                m_sub = 0;
                m_secs--;
                if (m_secs == 0) begin m_mode = M_DONE; entered = 1'b1; end
              end
            end
          end
          M_PAUSE: if (st) m_mode = M_RUN;
          default: begin
            if (!st && ld) begin m_secs = loaded_secs(mi, si); m_mode = M_IDLE; end
          end
        endcase
      end
      if (ca || ld) m_beep_left = 0;
      else if (entered) m_beep_left = BEEP_T;
      else if (m_mode == M_DONE && tk && m_beep_left > 0) m_beep_left--;
    end
`ifdef COOK_DONE_BEEP_EN
    bp = (m_beep_left > 0);
`else
    bp = 1'b0;
`endif
    exp_q.push_back({to_bcd(m_secs / 60), to_bcd(m_secs % 60),
                     logic'(m_mode == M_RUN), logic'(m_mode == M_PAUSE),
                     logic'(m_mode == M_DONE), entered, bp});
  endtask

  // One clock of stimulus: drive on the falling edge, record expectation.
  task automatic step(input logic r, input logic tk, input logic ld,
                      input logic st, input logic pa, input logic ca,
                      input logic [7:0] mi, input logic [7:0] si);
    @(negedge clock);
    reset = r; tick_in = tk; load = ld; start = st; pause = pa; cancel = ca;
    min_in = mi; sec_in = si;
    model_step(r, tk, ld, st, pa, ca, mi, si);
    if (!r || ld || st || pa || ca)
      $display("txn t=%0t rst_n=%b tick=%b load=%b %h:%h start=%b pause=%b cancel=%b",
               $time, r, tk, ld, mi, si, st, pa, ca);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_load(input logic [7:0] mi, input logic [7:0] si);
    step(1, 0, 1, 0, 0, 0, mi, si);
  endtask

  task automatic do_start();
    step(1, 0, 0, 1, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_cancel();
    step(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
  endtask

  // Monitor: every cycle the DUT presents registered outputs after the edge.
  initial begin
    logic [20:0] exp_v, act_v;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {min_out, sec_out, running, paused, done, done_pulse, beep};
        vectors++;
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs vec=%0d t=%0t got %h:%h r%b p%b d%b dp%b bp%b want %h:%h r%b p%b d%b dp%b bp%b",
                   vectors, $time, act_v[20:13], act_v[12:5], act_v[4], act_v[3],
                   act_v[2], act_v[1], act_v[0], exp_v[20:13], exp_v[12:5],
                   exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    logic r, tk, ld, st, pa, ca;
    logic [7:0] mi, si;
    int wait_cycles;

    // Power-on reset
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(2);

    // Basic countdown 00:02 to DONE
    do_load(8'h00, 8'h02);
    do_start();
    ticks(20);
    idle(3);
    step(1, 0, 0, 1, 0, 0, 8'h00, 8'h00);   // start ignored in DONE

    // Load in DONE returns to IDLE; borrow 10:00 -> 09:59
    do_load(8'h10, 8'h00);
    do_start();
    ticks(10);
    idle(2);
    do_cancel();
    do_load(8'h07, 8'h7A);                  // clamps to 07:59
    do_load(8'hAF, 8'hF9);                  // clamps to 99:59
    do_cancel();

    // Pause / resume
    do_load(8'h00, 8'h05);
    do_start();
    ticks(4);
    step(1, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    ticks(30);
    do_load(8'h03, 8'h00);                  // ignored in PAUSE
    do_start();
    ticks(6);
    do_cancel();

    // Priority: cancel + pause + tick in RUN; start with 00:00
    do_load(8'h00, 8'h03);
    do_start();
    ticks(9);
    step(1, 1, 0, 0, 1, 1, 8'h00, 8'h00);
    idle(1);
    do_start();
    idle(2);

    // Reset mid-RUN at 01:30
    do_load(8'h01, 8'h30);
    do_start();
    ticks(15);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    idle(2);

    // Completion and beep window, then load in DONE
    do_load(8'h00, 8'h01);
    do_start();
    ticks(10);
    ticks(22);
    do_load(8'h00, 8'h02);
    idle(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 999) != 0);
      tk = ($urandom_range(0, 1) == 0);
      ld = ($urandom_range(0, 24) == 0);
      st = ($urandom_range(0, 14) == 0);
      pa = ($urandom_range(0, 59) == 0);
      ca = ($urandom_range(0, 199) == 0);
      mi = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      si = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      step(r, tk, ld, st, pa, ca, mi, si);
    end
    idle(2);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clock);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cook_time_countdown.md
Name: cook_time_countdown

Overview:
- Consumer of the 100 ms tick stream. Counts down the microwave cook time held as BCD MM:SS, one second per TICKS_PER_SEC input ticks.
- Provides run, pause, cancel and done status to the control FSM, and BCD digits to the display path.
- Sits between the tick generator (tick source) and the control and display modules.

Parameters:
- TICKS_PER_SEC, 10: tick_in pulses per decremented second.
- BEEP_TICKS, 20: tick_in pulses that beep stays high after completion. Used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- tick_in  in  1  single-cycle 100 ms pulse from the tick generator.
- load  in  1  capture min_in/sec_in.
- min_in  in  8  BCD minutes, 00-99.
- sec_in  in  8  BCD seconds, 00-59.
- start  in  1  start or resume countdown.
- pause  in  1  pause countdown.
- cancel  in  1  abort and clear.
- min_out  out  8  current BCD minutes.
- sec_out  out  8  current BCD seconds.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE.
- done_pulse  out  1  one-cycle pulse on entry to DONE.
- beep  out  1  completion beep (optional feature).

Behaviour:
- All outputs registered. On reset low at a clock edge: state=IDLE, min_out=sec_out=8'h00, sub-second counter=0, all flags 0.
- States:
  - IDLE: load writes time. start with time!=00:00 -> RUN and clears the sub-counter. start with 00:00 is ignored.
  - RUN: each tick_in increments the sub-counter. When sub-counter==TICKS_PER_SEC-1 and tick_in is high: sub-counter=0 and time decrements by 1 s. If the result is 00:00 -> DONE in the same edge.
  - PAUSE: time and sub-counter are frozen. start -> RUN without clearing the sub-counter. load is ignored.
  - DONE: time reads 00:00. start is ignored. load writes time and -> IDLE.
- Transitions: pause in RUN -> PAUSE. cancel in any state -> IDLE with time=00:00 and sub-counter=0.
- Load clamping, applied per digit:
  - Any BCD digit >9 is clamped to 9.
  - Seconds tens >5 is clamped to 5, e.g. 8'h7A -> 8'h59.
  - load is ignored in RUN and PAUSE.
- BCD decrement:
  - sec ones 0 -> 9 with borrow to sec tens.
  - sec tens 0 with borrow -> 5, borrowing a minute.
  - min ones 0 -> 9 with borrow to min tens.
  - Example: 10:00 -> 09:59.
  - No decrement below 00:00.
- Same-cycle priority: reset > cancel > pause > start > load. A tick_in coincident with pause or cancel is dropped. A tick_in coincident with a start that leaves PAUSE is not counted.
- Status outputs:
  - done_pulse is high exactly one cycle, the first cycle done is high.
  - running, paused and done are mutually exclusive. All three are low in IDLE.
- Latency: min_out/sec_out update on the clock edge after the qualifying tick_in is sampled.

Optional Feature:
- Macro COOK_DONE_BEEP_EN.
- When defined:
  - beep rises with done and stays high for BEEP_TICKS tick_in pulses, then falls.
  - beep is cleared immediately by cancel, load or reset. It is not retriggered while in DONE.
- When undefined: beep is tied to 0 and the beep counter is not built.

Test Plan:
- Reset: hold reset=0 for 3 cycles mid-RUN at 01:30 -> min_out=00, sec_out=00, all flags 0 next edge.
- Basic countdown: load 00:02, start, supply 20 ticks -> 00:01 after tick 10, 00:00 plus done and a single done_pulse after tick 20, running=0.
- Borrow: load 10:00, start, 10 ticks -> 09:59. Load 8'h7A seconds -> sec_out=8'h59 after load.
- Pause/resume: load 00:05, start, 4 ticks, pause, 30 ticks, start, 6 ticks -> paused during the gap, time stays 00:05, reads 00:04 after the 6th post-resume tick.
- Priority: assert cancel and pause together with tick_in in RUN at 00:03 -> IDLE, 00:00, tick ignored. start with 00:00 loaded -> stays IDLE.
- COOK_DONE_BEEP_EN: BEEP_TICKS=20, reach DONE, supply 20 ticks -> beep high from the DONE edge and low after the 20th tick. Load in DONE -> beep=0 and IDLE next edge.
